fifo_burst_drain: RTL and testbench

FIFO_BURST_DRAIN -- requirements
Module: fifo_burst_drain

---
 rtl/fifo_burst_drain_pkg.sv | 17 +
 rtl/fifo_burst_drain.sv | 141 ++++++++++++++
 tb/tb_fifo_burst_drain.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_drain_pkg.sv
// rtl/fifo_burst_drain_pkg.sv - shared fifo type codes and drain FSM state encoding
package fifo_burst_drain_pkg;

    // Upstream FIFO flavours seen by readers in this codebase
    typedef enum logic [1:0] {
        FIFO_TYPE_SYNC  = 2'd0,
        FIFO_TYPE_ASYNC = 2'd1,
        FIFO_TYPE_FWFT  = 2'd2
    } fifo_type_e;

    // Burst drain controller states
    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_BURST = 1'b1
    } drain_state_e;

endpackage

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - drains a FWFT FIFO downstream in full or timed-out/flushed partial bursts
module fifo_burst_drain
    import fifo_burst_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_counter_i,
    output logic                  fifo_rd_valid_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  busy_o
);

    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int TMR_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0]  BURST_LEN_OCC   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  OCC_ZERO        = '0;
    localparam logic [BEAT_W-1:0] BURST_LEN_BEATS = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] ONE_BEAT        = BEAT_W'(1);
    localparam logic [TMR_W-1:0]  TIMER_MAX       = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TIMER_ONE       = TMR_W'(1);

    drain_state_e          state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic in_burst;
    logic pop;
    logic full_ready;
    logic partial_go;
    logic start_burst;
    logic last_pop;

    // Occupancy is only ever loaded below BURST_LEN on the partial path, so the
    // loaded count can never exceed what the FIFO currently holds.
    assign full_ready  = (fifo_counter_i >= BURST_LEN_OCC);
    assign partial_go  = (fifo_counter_i != OCC_ZERO) && ((timer_q == TIMER_MAX) || flush_i);
    assign start_burst = full_ready || partial_go;
    assign last_pop    = pop && (beat_q == ONE_BEAT);

    // State register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DRAIN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter BURST on threshold/timeout/flush, leave on the final pop
    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAIN_IDLE:  if (start_burst) state_d = DRAIN_BURST;
            DRAIN_BURST: if (last_pop)    state_d = DRAIN_IDLE;
            default:                      state_d = DRAIN_IDLE;
        endcase
    end

    // FSM outputs: pop only while bursting, data present and the output slot free
    always_comb begin
        in_burst        = (state_q == DRAIN_BURST);
        pop             = in_burst && !fifo_empty_i && (!m_valid_q || m_ready_i);
        busy_o          = in_burst;
        fifo_rd_valid_o = pop;
    end

    // Next values for the idle timer, beat counter and output slot
    always_comb begin
        timer_d   = timer_q;
        beat_d    = beat_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;

        if (in_burst || fifo_empty_i || start_burst) begin
            timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TIMER_ONE;
        end

        if (!in_burst) begin
            if (full_ready) begin
                beat_d = BURST_LEN_BEATS;
            end else if (partial_go) begin
                beat_d = fifo_counter_i[BEAT_W-1:0];
            end
        end else if (pop) begin
            beat_d = beat_q - ONE_BEAT;
        end

        if (pop) begin
            m_data_d  = fifo_data_i;
            m_valid_d = 1'b1;
            m_last_d  = (beat_q == ONE_BEAT);
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            beat_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            beat_q    <= beat_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    // Output data register carries no reset; it is qualified by m_valid_o
    always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
    end

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - self-checking bench for fifo_burst_drain
module tb_fifo_burst_drain;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int BL    = 8;
    localparam int TO    = 64;
    localparam int DEPTH = 1 << AW;
    localparam int CNT_W = AW + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    fifo_data_i;
    logic             fifo_empty_i;
    logic [CNT_W-1:0] fifo_counter_i;
    logic             fifo_rd_valid_o;
    logic             flush_i;
    logic [DW-1:0]    m_data_o;
    logic             m_valid_o;
    logic             m_last_o;
    logic             m_ready_i;
    logic             busy_o;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_data_i     (fifo_data_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_counter_i  (fifo_counter_i),
        .fifo_rd_valid_o (fifo_rd_valid_o),
        .flush_i         (flush_i),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_last_o        (m_last_o),
        .m_ready_i       (m_ready_i),
        .busy_o          (busy_o)
    );

    int total = 0;
    int bad   = 0;

    // upstream FWFT FIFO contents
    logic [DW-1:0] fq[$];

    // reference model: burst in progress, beats left, output slot, idle-with-data run length
    bit            mb, mv, ml;
    logic [DW-1:0] md;
    int            left, idle_run;

    // observations for the scenario table
    int          cyc, first_pop, beats, pops;
    logic [31:0] last_mask;

    typedef struct {
        int nwords;
        int flush_at;
        bit toggle;
        int first_pop;
        int last_mask;
    } scn_t;

    scn_t tbl[7];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic drive_fifo();
        fifo_empty_i   = (fq.size() == 0);
        fifo_data_i    = (fq.size() != 0) ? fq[0] : '0;
        fifo_counter_i = CNT_W'(fq.size());
    endtask

    function automatic void model_reset();
        mb = 0; mv = 0; ml = 0; md = '0; left = 0; idle_run = 0;
    endfunction

    // one clock cycle: check at negedge, advance model, apply the DUT's pop after the edge
    task automatic cycle();
        int  n;
        bit  exp_pop;
        bit  do_pop;
        @(negedge clk);
        n       = fq.size();
        exp_pop = mb && (n > 0) && (!mv || m_ready_i);
        check("rd_valid", 64'(fifo_rd_valid_o), 64'(exp_pop));
        check("busy", 64'(busy_o), 64'(mb));
        check("m_valid", 64'(m_valid_o), 64'(mv));
        if (mv) begin
            check("m_data", 64'(m_data_o), 64'(md));
            check("m_last", 64'(m_last_o), 64'(ml));
        end
        do_pop = fifo_rd_valid_o;
        if (do_pop) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (m_valid_o && m_ready_i) begin
            if (m_last_o && beats < 32) last_mask[beats] = 1'b1;
            beats++;
        end
        if (mb) begin
            if (exp_pop) begin
                md = fq[0]; mv = 1; left--; ml = (left == 0);
                if (left == 0) mb = 0;
            end else if (mv && m_ready_i) begin
                mv = 0;
            end
            idle_run = 0;
        end else begin
            if (mv && m_ready_i) mv = 0;
            if (n >= BL) begin
                mb = 1; left = BL; idle_run = 0;
            end else if (n > 0 && (flush_i || idle_run >= TO - 1)) begin
                mb = 1; left = n; idle_run = 0;
            end else if (n == 0) begin
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
        @(posedge clk);
        #1;
        if (do_pop) begin
            check("no_underflow", 64'(fq.size() > 0), 64'(1));
            if (fq.size() > 0) void'(fq.pop_front());
        end
        cyc++;
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        m_ready_i = 1'b1;
        fq.delete();
        drive_fifo();
        #1;
        check("rst_m_valid", 64'(m_valid_o), 64'(0));
        check("rst_m_last", 64'(m_last_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_rd_valid", 64'(fifo_rd_valid_o), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc = 0; first_pop = -1; beats = 0; pops = 0; last_mask = '0;
    endtask

    task automatic run_scn(input int idx, input scn_t s);
        do_reset();
        for (int c = 0; c < 110; c++) begin
            if (c < s.nwords) fq.push_back(DW'(c));
            flush_i   = (c == s.flush_at);
            m_ready_i = s.toggle ? (c % 2 == 0) : 1'b1;
            drive_fifo();
            cycle();
        end
        flush_i   = 1'b0;
        m_ready_i = 1'b1;
        check($sformatf("scn%0d_first_pop", idx), 64'(first_pop), 64'(s.first_pop));
        check($sformatf("scn%0d_beats", idx), 64'(beats), 64'(s.nwords));
        check($sformatf("scn%0d_last_mask", idx), 64'(last_mask), 64'(s.last_mask));
        check($sformatf("scn%0d_fifo_left", idx), 64'(fq.size()), 64'(0));
    endtask

    initial begin
        int k;
        int wcount;
        tbl[0] = '{8,  -1, 1'b0, 8,  'h80};
        tbl[1] = '{3,  -1, 1'b0, 64, 'h4};
        tbl[2] = '{5,  10, 1'b0, 11, 'h10};
        tbl[3] = '{8,  -1, 1'b1, 8,  'h80};
        tbl[4] = '{16, -1, 1'b0, 8,  'h8080};
        tbl[5] = '{0,   3, 1'b0, -1, 'h0};
        tbl[6] = '{3,   2, 1'b0, 3,  'h4};

        for (int i = 0; i < 7; i++) run_scn(i, tbl[i]);

        // reset in the middle of a burst
        do_reset();
        for (int c = 0; c < 8; c++) begin
            fq.push_back(DW'(c));
            drive_fifo();
            cycle();
        end
        k = 0;
        while (beats < 4 && k < 40) begin
            cycle();
            k++;
        end
        check("midrst_reach_beat3", 64'(beats >= 4), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid_o), 64'(0));
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_rd_valid", 64'(fifo_rd_valid_o), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        pops = 0; beats = 0; last_mask = '0;
        check("midrst_left_in_fifo", 64'(fq.size()), 64'(3));
        repeat (20) cycle();
        check("midrst_no_pop_below_threshold", 64'(pops), 64'(0));
        for (int c = 0; c < 5; c++) begin
            fq.push_back(DW'(100 + c));
            drive_fifo();
            cycle();
        end
        repeat (20) cycle();
        check("midrst_new_burst_beats", 64'(beats), 64'(8));
        check("midrst_new_burst_last", 64'(last_mask), 64'('h80));

        // randomized traffic against the reference model
        do_reset();
        wcount = 0;
        for (int c = 0; c < 3000; c++) begin
            if (((c / 300) % 2 == 0) && fq.size() < DEPTH && ($urandom % 3 != 0)) begin
                fq.push_back(DW'($urandom));
                wcount++;
            end
            m_ready_i = ($urandom % 4 != 0);
            flush_i   = ($urandom % 16 == 0);
            drive_fifo();
            cycle();
        end
        flush_i   = 1'b0;
        m_ready_i = 1'b1;
        drive_fifo();
        repeat (200) cycle();
        check("rand_drained", 64'(fq.size()), 64'(0));
        check("rand_beats", 64'(beats), 64'(wcount));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
